shift_seq_ctrl: RTL and testbench

Controller that sequences a WIDTH-bit serial-in shift register. It clears the register and enables exactly WIDTH shift cycles per frame. It then holds the captured word valid under a valid/ack handshake with the consumer. It sits between the frame-start source and the shift register's enable and clear inputs.

---
 rtl/shift_seq_ctrl.sv | 107 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a WIDTH-bit serial-in shift register: clear, WIDTH shift cycles, hold under valid/ack.
// Optional even-parity check after the data bits when PARITY_CHK_EN is defined.
module shift_seq_ctrl #(
  parameter  int WIDTH = 6,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          serIn,
  input  logic          ack,
  output logic          srEn,
  output logic          srClr,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] bitCnt,
  output logic          parErr
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
`ifdef PARITY_CHK_EN
    PARITY,
`endif
    HOLD
  } state_t;

  state_t state, nxt;
  logic   kill;

  // abort only matters once a frame is in flight
  assign kill = abort && (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (start) nxt = CLEAR;
      CLEAR:  nxt = SHIFT;
`ifdef PARITY_CHK_EN
      SHIFT:  if (bitCnt == LAST) nxt = PARITY;
      PARITY: nxt = HOLD;
`else
      SHIFT:  if (bitCnt == LAST) nxt = HOLD;
`endif
      HOLD:   if (ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bitCnt <= '0;
    else if (kill) bitCnt <= '0;
    else begin
      case (state)
        CLEAR:   bitCnt <= '0;
        SHIFT:   bitCnt <= bitCnt + 1'b1;
        HOLD:    if (ack) bitCnt <= '0;
        default: bitCnt <= bitCnt;
      endcase
    end
  end

  assign srEn  = (state == SHIFT);
  assign srClr = (state == CLEAR);
  assign busy  = (state != IDLE);
  assign valid = (state == HOLD);

`ifdef PARITY_CHK_EN
  logic parAcc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parAcc <= 1'b0;
      parErr <= 1'b0;
    end else if (kill) begin
      parAcc <= 1'b0;
      parErr <= 1'b0;
    end else begin
      case (state)
        CLEAR:   parAcc <= 1'b0;
        SHIFT:   parAcc <= parAcc ^ serIn;
        PARITY:  parErr <= parAcc ^ serIn;
        HOLD:    if (ack) parErr <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  // serial data is only observed for parity; nothing to do without the check
  logic unusedSerIn;
  assign unusedSerIn = serIn;
  assign parErr      = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus randomized frames
// checked cycle-by-cycle against a frame-level expectation built from the protocol rules.
module tb_shift_seq_ctrl;
  localparam int W  = 6;
  localparam int CW = $clog2(W+1);
  localparam int SW = 5 + CW;

`ifdef PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, serIn = 1'b0, ack = 1'b0;
  logic srEn, srClr, busy, valid, parErr;
  logic [CW-1:0] bitCnt;

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .serIn(serIn), .ack(ack),
    .srEn(srEn), .srClr(srClr), .busy(busy), .valid(valid), .bitCnt(bitCnt), .parErr(parErr)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] obs();
    return {srClr, srEn, busy, valid, parErr, bitCnt};
  endfunction

  function automatic logic [SW-1:0] mk(bit clr, bit en, bit bsy, bit vld, bit pe, int cnt);
    return {clr, en, bsy, vld, pe, CW'(cnt)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL reset: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL idle_after_reset: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
  endtask

  // One whole frame. data[k] is the k-th serial bit; noise pulses start while busy;
  // withStart raises start alongside ack, which must not launch a new frame.
  task automatic run_frame(input logic [W-1:0] data, input bit parBit, input int ackDelay,
                           input bit noise, input bit withStart, input string tag);
    bit expPe;
    expPe = PAR ? ((^data) ^ parBit) : 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs() !== mk(1,0,1,0,0,0)) begin
      errors++; $display("FAIL %s clear: got %b want %b", tag, obs(), mk(1,0,1,0,0,0));
    end
    if (noise) start = 1'($urandom);
    tick();
    for (int k = 0; k < W; k++) begin
      checks++;
      if (obs() !== mk(0,1,1,0,0,k)) begin
        errors++; $display("FAIL %s shift%0d: got %b want %b", tag, k, obs(), mk(0,1,1,0,0,k));
      end
      serIn = data[k];
      if (noise) start = 1'($urandom);
      tick();
    end
    if (PAR) begin
      checks++;
      if (obs() !== mk(0,0,1,0,0,W)) begin
        errors++; $display("FAIL %s parity: got %b want %b", tag, obs(), mk(0,0,1,0,0,W));
      end
      serIn = parBit;
      tick();
    end
    for (int d = 0; d <= ackDelay; d++) begin
      checks++;
      if (obs() !== mk(0,0,1,1,expPe,W)) begin
        errors++; $display("FAIL %s hold%0d: got %b want %b", tag, d, obs(), mk(0,0,1,1,expPe,W));
      end
      if (noise) start = 1'($urandom);
      serIn = 1'($urandom);
      if (d < ackDelay) tick();
    end
    ack = 1'b1; start = withStart;
    tick();
    ack = 1'b0; start = 1'b0;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL %s release: got %b want %b", tag, obs(), mk(0,0,0,0,0,0));
    end
    tick();
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL %s stay_idle: got %b want %b", tag, obs(), mk(0,0,0,0,0,0));
    end
  endtask

  task automatic test_basic_frame();
    run_frame(6'b001011, 1'b1, 3, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_parity_vectors();
    // bits 1,1,0,1,0,0: parity bit 1 is even, parity bit 0 is an error
    run_frame(6'b001011, 1'b0, 1, 1'b0, 1'b0, "par_bad");
    run_frame(6'b001011, 1'b1, 0, 1'b0, 1'b0, "par_good");
  endtask

  task automatic test_ack_with_start();
    run_frame(6'b110100, 1'b0, 0, 1'b0, 1'b1, "ack_start");
    run_frame(6'b010101, 1'b1, 2, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_idle_ack();
    ack = 1'b1; abort = 1'b1; tick(); tick();
    ack = 1'b0; abort = 1'b0;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL idle_ack_abort: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin serIn = 1'($urandom); tick(); end
    checks++;
    if (obs() !== mk(0,1,1,0,0,3)) begin
      errors++; $display("FAIL abort_pre: got %b want %b", obs(), mk(0,1,1,0,0,3));
    end
    abort = 1'b1; ack = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0; start = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      checks++;
      if (obs() !== mk(0,0,0,0,0,0)) begin
        errors++; $display("FAIL abort_idle%0d: got %b want %b", k, obs(), mk(0,0,0,0,0,0));
      end
      tick();
    end
  endtask

  task automatic test_abort_hold();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < W + 1 + int'(PAR); k++) begin serIn = 1'b1; tick(); end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL abort_hold_pre: valid=%b want 1", valid);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL abort_hold: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    #3 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL async_reset: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
    #2 rst = 1'b1;
    tick();
    checks++;
    if (obs() !== mk(0,0,0,0,0,0)) begin
      errors++; $display("FAIL async_release: got %b want %b", obs(), mk(0,0,0,0,0,0));
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 12; n++)
      run_frame(W'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b1,
                1'($urandom), $sformatf("rnd%0d", n));
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_vectors();
    test_ack_with_start();
    test_idle_ack();
    test_abort();
    test_abort_hold();
    test_async_reset();
    test_random_frames();
    test_basic_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
